pc_sequencer: RTL

- Program-counter / fetch sequencer; the consumer end of the control decoder's flow-control outputs (jump, call, ret).
- Holds the PC and a hardware return-address stack (RAS).
- Resolves jump/call/ret with condition qualification.
- Presents the next instruction address to instruction memory and reports done/fault status to the top level.

---
 rtl/pc_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter / fetch sequencer with a hardware
// return-address stack (RAS). Resolves halt/ret/call/jump in that priority
// order, one update per non-stalled RUN cycle, and reports run/done/fault.
//
// Optional feature macro: PC_RETIRE_COUNT_EN (adds the 'retired' counter).
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-high reset
//   start    - pulse; begin execution at PC 0 from IDLE or DONE
//   halt     - current instruction terminates the program
//   stall    - freeze PC, stack and state this cycle
//   jump     - flow-change request (qualified by cond_ok)
//   cond_ok  - jump condition satisfied
//   call     - current instruction is CALL (push return address)
//   ret      - current instruction is RET (pop return address)
//   target   - absolute jump/call destination
//   pc       - current instruction address (registered)
//   running  - high in RUN
//   done     - high in DONE
//   fault    - high in FAULT (RAS overflow/underflow, sticky)
//   depth    - RAS occupancy
//   retired  - saturating count of executed instructions (macro only)
module pc_sequencer #(
    parameter int unsigned PCWidth    = 10,
    parameter int unsigned StackDepth = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          halt,
    input  logic                          stall,
    input  logic                          jump,
    input  logic                          cond_ok,
    input  logic                          call,
    input  logic                          ret,
    input  logic [PCWidth-1:0]            target,
    output logic [PCWidth-1:0]            pc,
    output logic                          running,
    output logic                          done,
    output logic                          fault,
    output logic [$clog2(StackDepth):0]   depth
`ifdef PC_RETIRE_COUNT_EN
    ,
    output logic [31:0]                   retired
`endif
);

    localparam int unsigned AddrW  = $clog2(StackDepth);
    localparam int unsigned DepthW = AddrW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PCWidth-1:0]    r_pc;
    logic [PCWidth-1:0]    w_pc_nxt;
    logic [PCWidth-1:0]    w_pc_inc;
    logic [DepthW-1:0]     r_depth;
    logic [DepthW-1:0]     w_depth_nxt;
    logic                  w_push;
    logic [AddrW-1:0]      w_push_idx;
    logic [AddrW-1:0]      w_pop_idx;
    logic [PCWidth-1:0]    r_ras [StackDepth];
    logic                  r_running;
    logic                  r_done;
    logic                  r_fault;

    // Return address wraps naturally at 2^PCWidth.
    assign w_pc_inc   = r_pc + PCWidth'(1);
    assign w_push_idx = AddrW'(r_depth);
    assign w_pop_idx  = AddrW'(r_depth - DepthW'(1));

    // Next-state, next-PC and stack control.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_depth_nxt = r_depth;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = '0;
                    w_depth_nxt = '0;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    if (halt) begin
                        w_state_nxt = S_DONE;
                    end else if (ret) begin
                        if (r_depth != '0) begin
                            w_pc_nxt    = r_ras[w_pop_idx];
                            w_depth_nxt = r_depth - DepthW'(1);
                        end else begin
                            w_state_nxt = S_FAULT;
                        end
                    end else if (call) begin
                        if (r_depth == DepthW'(StackDepth)) begin
                            w_state_nxt = S_FAULT;
                        end else begin
                            w_push      = 1'b1;
                            w_pc_nxt    = target;
                            w_depth_nxt = r_depth + DepthW'(1);
                        end
                    end else if (jump && cond_ok) begin
                        w_pc_nxt = target;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
            end
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
        endcase
    end

    // State, PC, depth and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_depth   <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_depth   <= w_depth_nxt;
            r_running <= (w_state_nxt == S_RUN);
            r_done    <= (w_state_nxt == S_DONE);
            r_fault   <= (w_state_nxt == S_FAULT);
        end
    end

    // RAS storage; contents are don't-care after reset so no reset term.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras[w_push_idx] <= w_pc_inc;
        end
    end

`ifdef PC_RETIRE_COUNT_EN
    logic        w_cnt_clear;
    logic        w_cnt_inc;
    logic [31:0] r_retired;

    // Every non-stalled RUN cycle retires one instruction, halt included.
    always_comb begin
        w_cnt_clear = start && ((r_state == S_IDLE) || (r_state == S_DONE));
        w_cnt_inc   = (r_state == S_RUN) && !stall;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= '0;
        end else if (w_cnt_clear) begin
            r_retired <= '0;
        end else if (w_cnt_inc && (r_retired != 32'hFFFF_FFFF)) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign retired = r_retired;
`endif

    assign pc      = r_pc;
    assign depth   = r_depth;
    assign running = r_running;
    assign done    = r_done;
    assign fault   = r_fault;

endmodule
